// File: rtl/ohc9_adder_arbiter.sv
// Round-robin arbiter feeding one shared one-hot mod-9 adder. One request
// is accepted per cycle and produces a single registered result that carries
// the winner's ID and an operand-legality flag. Saturating counters track
// how many requests were accepted and how many had illegal operands.

// One-hot mod-9 adder: bit k of the sum is set when a[i] and b[(k-i) mod 9]
// are both set for some i. Legal one-hot inputs give a one-hot output.
module ohc_9_modulo_adder (
    input  logic [8:0] a_i,
    input  logic [8:0] b_i,
    output logic [8:0] sum_o
);

    // OR together every operand bit pair whose residues add up to k mod 9
    always_comb begin
        sum_o = 9'b0;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 9; i++) begin
                sum_o[k] = sum_o[k] | (a_i[i] & b_i[(k + 9 - i) % 9]);
            end
        end
    end

endmodule

module ohc9_adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [9*N_REQ-1:0]   req_a,
    input  logic [9*N_REQ-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8:0]           res_sum,
    output logic [ID_W-1:0]      res_id,
    output logic                 res_err,
    output logic [CNT_W-1:0]     ops_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    // An operand is legal only when exactly one of its nine bits is set.
    function automatic logic is_onehot9(input logic [8:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return (cnt == 4'd1);
    endfunction

    // Counter increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  win_id_s;
    logic             can_accept_s;
    logic             accept_s;
    logic [8:0]       op_a_s;
    logic [8:0]       op_b_s;
    logic [8:0]       add_sum_s;
    logic             ops_legal_s;

    logic             res_valid_q, res_valid_d;
    logic [8:0]       res_sum_q,   res_sum_d;
    logic [ID_W-1:0]  res_id_q,    res_id_d;
    logic             res_err_q,   res_err_d;
    logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0] ops_cnt_q,   ops_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

    // The result slot can take a new sum when it is empty or being drained now.
    assign can_accept_s = ~res_valid_q | res_ready;

    // Rotating-priority search: first valid requester at or after rr_ptr.
    always_comb begin
        logic found;
        int   idx;
        grant_s  = '0;
        win_id_s = '0;
        found    = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(rr_ptr_q) + off) % N_REQ;
            if (!found && req_valid[idx]) begin
                found        = 1'b1;
                grant_s[idx] = 1'b1;
                win_id_s     = ID_W'(idx);
            end else begin
                found = found;
            end
        end
    end

    // Grants are only exposed when the result slot has room and not in reset.
    assign req_ready = grant_s & {N_REQ{can_accept_s & ~rst}};
    assign accept_s  = |req_ready;

    // Steer the winning requester's operand pair into the shared adder.
    always_comb begin
        op_a_s = 9'b0;
        op_b_s = 9'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                op_a_s = req_a[i*9 +: 9];
                op_b_s = req_b[i*9 +: 9];
            end else begin
                op_a_s = op_a_s;
                op_b_s = op_b_s;
            end
        end
    end

    ohc_9_modulo_adder u_adder (
        .a_i   (op_a_s),
        .b_i   (op_b_s),
        .sum_o (add_sum_s)
    );

    assign ops_legal_s = is_onehot9(op_a_s) & is_onehot9(op_b_s);

    // Next state of the result slot, round-robin pointer and statistics.
    always_comb begin
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        rr_ptr_d    = rr_ptr_q;
        ops_cnt_d   = ops_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (accept_s) begin
            res_valid_d = 1'b1;
            res_sum_d   = ops_legal_s ? add_sum_s : 9'b0;
            res_id_d    = win_id_s;
            res_err_d   = ~ops_legal_s;
            if (win_id_s == ID_W'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_id_s + ID_W'(1);
            end
            ops_cnt_d = sat_inc(ops_cnt_q);
            if (!ops_legal_s) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else if (res_ready) begin
            // Drained with nothing new: payload holds, only valid drops.
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_sum_q   <= 9'b0;
            res_id_q    <= '0;
            res_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
            ops_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
            rr_ptr_q    <= rr_ptr_d;
            ops_cnt_q   <= ops_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign ops_cnt   = ops_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ohc9_adder_arbiter.sv
// Directed bench for ohc9_adder_arbiter: reset, single op, round robin,
// backpressure, illegal operands, exhaustive legal sweep, reset mid-stream
// and counter saturation (on a second instance with narrow counters).
module tb_ohc9_adder_arbiter;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [9*N-1:0] req_a;
    logic [9*N-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [8:0]     res_sum;
    logic [1:0]     res_id;
    logic           res_err;
    logic [15:0]    ops_cnt;
    logic [15:0]    err_cnt;

    logic [N-1:0]   s_req_ready;
    logic           s_res_valid;
    logic [8:0]     s_res_sum;
    logic [1:0]     s_res_id;
    logic           s_res_err;
    logic [1:0]     s_ops_cnt;
    logic [1:0]     s_err_cnt;

    int checks;
    int errors;

    ohc9_adder_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_id(res_id), .res_err(res_err),
        .ops_cnt(ops_cnt), .err_cnt(err_cnt)
    );

    ohc9_adder_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(s_res_valid), .res_ready(res_ready),
        .res_sum(s_res_sum), .res_id(s_res_id), .res_err(s_res_err),
        .ops_cnt(s_ops_cnt), .err_cnt(s_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; res_ready = 1'b0;
        req_a = '0; req_b = '0;
        step(); step();
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++;
        if ({res_valid, res_sum, res_id, res_err} !== 13'd0) begin errors++; $display("FAIL reset_res got v=%b s=%h id=%0d e=%b want all 0", res_valid, res_sum, res_id, res_err); end
        checks++;
        if (ops_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got ops=%0d err=%0d want 0 0", ops_cnt, err_cnt); end
        req_valid = '0;
    endtask

    task automatic test_single_op();
        do_reset();
        res_ready = 1'b1;
        req_a[0 +: 9] = 9'h020; req_b[0 +: 9] = 9'h080; req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 9'h008 || res_id !== 2'd0 || res_err !== 1'b0 || ops_cnt !== 16'd1) begin
            errors++; $display("FAIL single_res got v=%b s=%h id=%0d e=%b ops=%0d want 1 008 0 0 1", res_valid, res_sum, res_id, res_err, ops_cnt);
        end
        step();
        checks++;
        if (res_valid !== 1'b0 || res_sum !== 9'h008) begin errors++; $display("FAIL single_drain got v=%b s=%h want 0 008", res_valid, res_sum); end
    endtask

    task automatic test_round_robin();
        logic [8:0] exp_sum;
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_a[i*9 +: 9] = 9'(1 << i);
            req_b[i*9 +: 9] = 9'h002;
        end
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #0;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_ready k=%0d got %b want %b", k, req_ready, 4'(1 << (k % 4))); end
            step();
            exp_sum = 9'(1 << ((k % 4) + 1));
            checks++;
            if (res_valid !== 1'b1 || res_id !== 2'(k % 4) || res_sum !== exp_sum) begin
                errors++; $display("FAIL rr_res k=%0d got v=%b id=%0d s=%h want 1 %0d %h", k, res_valid, res_id, res_sum, k % 4, exp_sum);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        // Pointer sits at 0 after the round-robin test; slot is empty.
        res_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_ready got %b want 0001", req_ready); end
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (req_ready !== 4'b0000 || res_valid !== 1'b1 || res_id !== 2'd0 || res_sum !== 9'h002 || res_err !== 1'b0) begin
                errors++; $display("FAIL bp_hold c=%0d got rdy=%b v=%b id=%0d s=%h want 0000 1 0 002", c, req_ready, res_valid, res_id, res_sum);
            end
            step();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b want 0010", req_ready); end
        step();
        checks++;
        if (res_id !== 2'd1 || res_sum !== 9'h004) begin errors++; $display("FAIL bp_release_res got id=%0d s=%h want 1 004", res_id, res_sum); end
        req_valid = '0;
        step();
    endtask

    task automatic test_illegal();
        do_reset();
        res_ready = 1'b1;
        req_a[18 +: 9] = 9'h003; req_b[18 +: 9] = 9'h001; req_valid = 4'b0100;
        step();
        checks++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_sum !== 9'h000 || res_id !== 2'd2 || err_cnt !== 16'd1) begin
            errors++; $display("FAIL illegal_res got v=%b e=%b s=%h id=%0d ecnt=%0d want 1 1 000 2 1", res_valid, res_err, res_sum, res_id, err_cnt);
        end
        req_a[18 +: 9] = 9'h100; req_b[18 +: 9] = 9'h100;
        step();
        checks++;
        if (res_err !== 1'b0 || res_sum !== 9'h080 || err_cnt !== 16'd1 || ops_cnt !== 16'd2) begin
            errors++; $display("FAIL legal_after got e=%b s=%h ecnt=%0d ops=%0d want 0 080 1 2", res_err, res_sum, err_cnt, ops_cnt);
        end
        req_valid = 4'b0001; req_a[0 +: 9] = 9'h000; req_b[0 +: 9] = 9'h010;
        step();
        checks++;
        if (res_err !== 1'b1 || res_sum !== 9'h000 || res_id !== 2'd0 || err_cnt !== 16'd2) begin
            errors++; $display("FAIL zero_operand got e=%b s=%h id=%0d ecnt=%0d want 1 000 0 2", res_err, res_sum, res_id, err_cnt);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_sweep();
        logic [8:0] exp_sum;
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b0010;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) begin
                req_a[9 +: 9] = 9'(1 << i);
                req_b[9 +: 9] = 9'(1 << j);
                step();
                exp_sum = 9'(1 << ((i + j) % 9));
                checks++;
                if (res_sum !== exp_sum || res_id !== 2'd1 || res_err !== 1'b0 || res_valid !== 1'b1) begin
                    errors++; $display("FAIL sweep i=%0d j=%0d got s=%h id=%0d e=%b want %h 1 0", i, j, res_sum, res_id, res_err, exp_sum);
                end
            end
        end
        checks++;
        if (ops_cnt !== 16'd81 || err_cnt !== 16'd0) begin errors++; $display("FAIL sweep_cnt got ops=%0d err=%0d want 81 0", ops_cnt, err_cnt); end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        // Pointer is 2 after the sweep, so requester 3 wins first here.
        res_ready = 1'b0;
        req_a[27 +: 9] = 9'h001; req_b[27 +: 9] = 9'h001;
        req_valid = 4'b1010;
        step();
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd3) begin errors++; $display("FAIL mid_pending got v=%b id=%0d want 1 3", res_valid, res_id); end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b want 0000", req_ready); end
        step();
        checks++;
        if (res_valid !== 1'b0 || ops_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_rst_state got v=%b ops=%0d err=%0d want 0 0 0", res_valid, ops_cnt, err_cnt);
        end
        rst = 1'b0; res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_after_ready got %b want 0010", req_ready); end
        step();
        checks++;
        if (res_id !== 2'd1 || ops_cnt !== 16'd1) begin errors++; $display("FAIL mid_after_res got id=%0d ops=%0d want 1 1", res_id, ops_cnt); end
        req_valid = '0;
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        res_ready = 1'b1;
        req_a[0 +: 9] = 9'h000; req_b[0 +: 9] = 9'h000;
        req_valid = 4'b0001;
        step(); step();
        checks++;
        if (s_ops_cnt !== 2'd2 || s_err_cnt !== 2'd2) begin errors++; $display("FAIL sat_pre got ops=%0d err=%0d want 2 2", s_ops_cnt, s_err_cnt); end
        step(); step(); step();
        checks++;
        if (s_ops_cnt !== 2'd3 || s_err_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold got ops=%0d err=%0d want 3 3", s_ops_cnt, s_err_cnt); end
        checks++;
        if (ops_cnt !== 16'd5 || err_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide got ops=%0d err=%0d want 5 5", ops_cnt, err_cnt); end
        req_valid = '0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_sweep();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
